// File: rtl/note_poly_prio.sv
`default_nettype none
// ============================================================================
// Module      : note_poly_prio
// Description : Monophonic note-priority allocator. Keeps an insertion-ordered
//               list of held notes {note, vel} and selects one for the mono
//               voice using highest, lowest or last-note priority. Handles
//               re-strikes (move to newest) and steals the oldest entry when
//               the list is full. One event is processed at a time through a
//               sequential SCAN / SHIFT / INSERT / EVAL / COMMIT walk.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-low reset
//               note_on    - key-press strobe (1 cycle)
//               note_off   - key-release strobe (1 cycle)
//               note       - key number, valid with a strobe
//               vel        - velocity, valid with note_on
//               mode       - 0 highest, 1 lowest, 2/3 last
//               out_note   - selected note (0 while gate is low)
//               out_vel    - selected velocity (0 while gate is low)
//               out_gate   - high while at least one note is held
//               out_retrig - 1-cycle envelope restart request
//               busy       - high while an event is in flight
//               dropped    - 1-cycle pulse when a strobe is ignored
//               overflow   - 1-cycle pulse when the oldest note is stolen
// Revision    : 1.0 - initial release
// ============================================================================
module note_poly_prio #(
    parameter int MAX_NOTES = 32,
    parameter int VEL_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_on,
    input  logic             note_off,
    input  logic [6:0]       note,
    input  logic [VEL_W-1:0] vel,
    input  logic [1:0]       mode,
    output logic [6:0]       out_note,
    output logic [VEL_W-1:0] out_vel,
    output logic             out_gate,
    output logic             out_retrig,
    output logic             busy,
    output logic             dropped,
    output logic             overflow
);

    localparam int CNT_W = $clog2(MAX_NOTES + 1);
    localparam int IDX_W = $clog2(MAX_NOTES);

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(MAX_NOTES);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_SHIFT  = 3'd2,
        S_INSERT = 3'd3,
        S_EVAL   = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [6:0]       r_mem_note [MAX_NOTES];
    logic [VEL_W-1:0] r_mem_vel  [MAX_NOTES];

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_idx;
    logic             r_found;
    logic [CNT_W-1:0] r_fidx;
    logic [6:0]       r_lnote;
    logic [VEL_W-1:0] r_lvel;
    logic [1:0]       r_lmode;
    logic             r_is_on;
    logic             r_steal;
    logic [6:0]       r_best_note;
    logic [VEL_W-1:0] r_best_vel;

    logic [6:0]       r_out_note;
    logic [VEL_W-1:0] r_out_vel;
    logic             r_out_gate;
    logic             r_retrig;
    logic             r_busy;
    logic             r_dropped;
    logic             r_overflow;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [6:0]       w_rd_note;
    logic [VEL_W-1:0] w_rd_vel;
    logic [CNT_W-1:0] w_idx_p1;
    logic             w_at_last;
    logic             w_match;
    logic             w_found;
    logic [CNT_W-1:0] w_fidx;
    logic             w_rm_needed;
    logic [CNT_W-1:0] w_rm_idx;
    state_t           w_after_rm;
    logic             w_better;
    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    logic [6:0]       w_wnote;
    logic [VEL_W-1:0] w_wvel;
    logic             w_strobe;

    assign w_strobe  = note_on | note_off;
    assign w_rd_note = r_mem_note[r_idx[IDX_W-1:0]];
    assign w_rd_vel  = r_mem_vel[r_idx[IDX_W-1:0]];
    assign w_idx_p1  = r_idx + C_ONE;
    assign w_at_last = (r_idx == (r_count - C_ONE));

    // The match on the entry under the scan pointer this cycle must be folded
    // in, since the final SCAN cycle decides the next state immediately.
    assign w_match   = (r_count != '0) && (w_rd_note == r_lnote);
    assign w_found   = r_found | w_match;
    assign w_fidx    = w_match ? r_idx : r_fidx;

    // A note_on that misses on a full list steals the oldest entry (index 0).
    assign w_rm_needed = w_found || (r_is_on && (r_count == C_FULL));
    assign w_rm_idx    = w_found ? w_fidx : '0;
    assign w_after_rm  = r_is_on ? S_INSERT : S_EVAL;

    // Priority comparison for the running best during EVAL. Notes in the list
    // are unique, so strict comparisons never tie. Last-note simply keeps
    // overwriting, ending on index count-1.
    always_comb begin
        w_better = 1'b1;
        case (r_lmode)
            2'd0:    w_better = (w_rd_note > r_best_note);
            2'd1:    w_better = (w_rd_note < r_best_note);
            default: w_better = 1'b1;
        endcase
    end

    // List write port: SHIFT pulls entry i+1 down into i, INSERT appends.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = '0;
        w_wnote = '0;
        w_wvel  = '0;
        if (r_state == S_SHIFT) begin
            w_we    = 1'b1;
            w_widx  = r_idx[IDX_W-1:0];
            w_wnote = r_mem_note[w_idx_p1[IDX_W-1:0]];
            w_wvel  = r_mem_vel[w_idx_p1[IDX_W-1:0]];
        end else if (r_state == S_INSERT) begin
            w_we    = 1'b1;
            w_widx  = r_count[IDX_W-1:0];
            w_wnote = r_lnote;
            w_wvel  = r_lvel;
        end
    end

    // List storage has no reset: entries at or above count are never read.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_note[w_widx] <= w_wnote;
            r_mem_vel[w_widx]  <= w_wvel;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_found     <= 1'b0;
            r_fidx      <= '0;
            r_lnote     <= '0;
            r_lvel      <= '0;
            r_lmode     <= '0;
            r_is_on     <= 1'b0;
            r_steal     <= 1'b0;
            r_best_note <= '0;
            r_best_vel  <= '0;
            r_out_note  <= '0;
            r_out_vel   <= '0;
            r_out_gate  <= 1'b0;
            r_retrig    <= 1'b0;
            r_busy      <= 1'b0;
            r_dropped   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_retrig   <= 1'b0;
            r_overflow <= 1'b0;
            r_dropped  <= (r_state != S_IDLE) && w_strobe;

            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        r_lnote   <= note;
                        r_lvel    <= vel;
                        r_lmode   <= mode;
                        r_is_on   <= note_on;
                        // Simultaneous on/off: the on wins, the off is lost.
                        r_dropped <= note_on & note_off;
                        r_idx     <= '0;
                        r_found   <= 1'b0;
                        r_fidx    <= '0;
                        r_steal   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if ((r_count == '0) || w_at_last) begin
                        if (w_rm_needed) begin
                            r_steal <= r_is_on && !w_found;
                            if (w_rm_idx == (r_count - C_ONE)) begin
                                // Removing the newest entry needs no shifting.
                                r_count <= r_count - C_ONE;
                                r_idx   <= '0;
                                r_state <= w_after_rm;
                            end else begin
                                r_idx   <= w_rm_idx;
                                r_state <= S_SHIFT;
                            end
                        end else if (r_is_on) begin
                            r_state <= S_INSERT;
                        end else begin
                            // Release of a note that is not held: no effect.
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_found <= w_found;
                        r_fidx  <= w_fidx;
                        r_idx   <= w_idx_p1;
                    end
                end

                S_SHIFT: begin
                    if (r_idx == (r_count - C_TWO)) begin
                        r_count <= r_count - C_ONE;
                        r_idx   <= '0;
                        r_state <= w_after_rm;
                    end else begin
                        r_idx <= w_idx_p1;
                    end
                end

                S_INSERT: begin
                    r_count    <= r_count + C_ONE;
                    r_overflow <= r_steal;
                    r_idx      <= '0;
                    r_state    <= S_EVAL;
                end

                S_EVAL: begin
                    if (r_count == '0) begin
                        r_best_note <= '0;
                        r_best_vel  <= '0;
                        r_state     <= S_COMMIT;
                    end else begin
                        if ((r_idx == '0) || w_better) begin
                            r_best_note <= w_rd_note;
                            r_best_vel  <= w_rd_vel;
                        end
                        if (w_at_last) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_idx <= w_idx_p1;
                        end
                    end
                end

                S_COMMIT: begin
                    if (r_count != '0) begin
                        r_out_gate <= 1'b1;
                        r_out_note <= r_best_note;
                        r_out_vel  <= r_best_vel;
                        r_retrig   <= !r_out_gate
                                   || (r_best_note != r_out_note)
                                   || (r_is_on && (r_best_note == r_lnote));
                    end else begin
                        r_out_gate <= 1'b0;
                        r_out_note <= '0;
                        r_out_vel  <= '0;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_note   = r_out_note;
    assign out_vel    = r_out_vel;
    assign out_gate   = r_out_gate;
    assign out_retrig = r_retrig;
    assign busy       = r_busy;
    assign dropped    = r_dropped;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_note_poly_prio.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_poly_prio
// Description : Directed self-checking bench for note_poly_prio. Each step
//               sends one event, measures accept-to-commit latency and counts
//               the pulse outputs, then compares against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_poly_prio;

    logic       clk = 1'b0;
    logic       rst;
    logic       note_on;
    logic       note_off;
    logic [6:0] note;
    logic [6:0] vel;
    logic [1:0] mode;
    logic [6:0] out_note;
    logic [6:0] out_vel;
    logic       out_gate;
    logic       out_retrig;
    logic       busy;
    logic       dropped;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int g_lat;
    int g_retrig;
    int g_ovf;
    int g_drop;

    note_poly_prio #(.MAX_NOTES(32), .VEL_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .note_on    (note_on),
        .note_off   (note_off),
        .note       (note),
        .vel        (vel),
        .mode       (mode),
        .out_note   (out_note),
        .out_vel    (out_vel),
        .out_gate   (out_gate),
        .out_retrig (out_retrig),
        .busy       (busy),
        .dropped    (dropped),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Send one event and follow it until busy falls, plus one trailing cycle
    // so that a stuck pulse output shows up as an extra count.
    task automatic send(input logic on, input logic off, input int n, input int v,
                        input int m, input logic inject);
        int guard;
        @(negedge clk);
        note_on  = on;
        note_off = off;
        note     = 7'(n);
        vel      = 7'(v);
        mode     = 2'(m);
        @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b0;
        g_lat    = 0;
        g_retrig = int'(out_retrig);
        g_ovf    = int'(overflow);
        g_drop   = int'(dropped);
        guard    = 0;
        while (busy && guard < 300) begin
            if (inject && g_lat == 1) begin
                note_on = 1'b1;
                note    = 7'd100;
            end
            @(negedge clk);
            note_on  = 1'b0;
            g_lat++;
            guard++;
            g_retrig += int'(out_retrig);
            g_ovf    += int'(overflow);
            g_drop   += int'(dropped);
        end
        if (guard >= 300) chk("busy_timeout", int'(busy), 0);
        @(negedge clk);
        g_retrig += int'(out_retrig);
        g_ovf    += int'(overflow);
        g_drop   += int'(dropped);
    endtask

    initial begin
        rst      = 1'b0;
        note_on  = 1'b0;
        note_off = 1'b0;
        note     = '0;
        vel      = '0;
        mode     = '0;
        repeat (3) @(negedge clk);
        chk("rst_gate",  int'(out_gate),   0);
        chk("rst_note",  int'(out_note),   0);
        chk("rst_vel",   int'(out_vel),    0);
        chk("rst_busy",  int'(busy),       0);
        chk("rst_pulse", int'({out_retrig, dropped, overflow}), 0);
        rst = 1'b1;
        @(negedge clk);

        // Highest priority: 60, 64, 55, release 64.
        send(1, 0, 60, 100, 0, 0);
        chk("m0_on60_lat",    g_lat, 4);
        chk("m0_on60_gate",   int'(out_gate), 1);
        chk("m0_on60_note",   int'(out_note), 60);
        chk("m0_on60_vel",    int'(out_vel), 100);
        chk("m0_on60_retrig", g_retrig, 1);
        chk("m0_on60_ovf",    g_ovf, 0);
        send(1, 0, 64, 80, 0, 0);
        chk("m0_on64_lat",    g_lat, 5);
        chk("m0_on64_note",   int'(out_note), 64);
        chk("m0_on64_vel",    int'(out_vel), 80);
        chk("m0_on64_retrig", g_retrig, 1);
        send(1, 0, 55, 70, 0, 0);
        chk("m0_on55_lat",    g_lat, 7);
        chk("m0_on55_note",   int'(out_note), 64);
        chk("m0_on55_retrig", g_retrig, 0);
        send(0, 1, 64, 0, 0, 0);
        chk("m0_off64_lat",    g_lat, 7);
        chk("m0_off64_note",   int'(out_note), 60);
        chk("m0_off64_vel",    int'(out_vel), 100);
        chk("m0_off64_retrig", g_retrig, 1);
        // Release of a note not held: scan only, nothing changes.
        send(0, 1, 99, 0, 0, 0);
        chk("miss_lat",    g_lat, 2);
        chk("miss_note",   int'(out_note), 60);
        chk("miss_retrig", g_retrig, 0);
        send(0, 1, 60, 0, 0, 0);
        chk("m0_off60_lat",  g_lat, 5);
        chk("m0_off60_note", int'(out_note), 55);
        chk("m0_off60_vel",  int'(out_vel), 70);
        send(0, 1, 55, 0, 0, 0);
        chk("empty_lat",    g_lat, 3);
        chk("empty_gate",   int'(out_gate), 0);
        chk("empty_note",   int'(out_note), 0);
        chk("empty_vel",    int'(out_vel), 0);
        chk("empty_retrig", g_retrig, 0);

        // Last-note priority.
        send(1, 0, 60, 11, 2, 0);
        send(1, 0, 55, 22, 2, 0);
        chk("m2_on55_lat",    g_lat, 5);
        chk("m2_on55_note",   int'(out_note), 55);
        chk("m2_on55_retrig", g_retrig, 1);
        send(0, 1, 55, 0, 2, 0);
        chk("m2_off55_lat",  g_lat, 4);
        chk("m2_off55_note", int'(out_note), 60);
        chk("m2_off55_vel",  int'(out_vel), 11);
        send(0, 1, 60, 0, 2, 0);
        chk("m2_clear_gate", int'(out_gate), 0);

        // Lowest priority.
        send(1, 0, 60, 11, 1, 0);
        send(1, 0, 55, 22, 1, 0);
        chk("m1_on55_note", int'(out_note), 55);
        send(1, 0, 70, 33, 1, 0);
        chk("m1_on70_note",   int'(out_note), 55);
        chk("m1_on70_retrig", g_retrig, 0);
        send(0, 1, 55, 0, 1, 0);
        chk("m1_off55_note", int'(out_note), 60);
        send(0, 1, 60, 0, 1, 0);
        send(0, 1, 70, 0, 1, 0);
        chk("m1_clear_gate", int'(out_gate), 0);

        // Re-strike in last-note mode.
        send(1, 0, 60, 10, 2, 0);
        send(1, 0, 62, 20, 2, 0);
        chk("rs_on62_note", int'(out_note), 62);
        send(1, 0, 60, 90, 2, 0);
        chk("rs_lat",    g_lat, 7);
        chk("rs_note",   int'(out_note), 60);
        chk("rs_vel",    int'(out_vel), 90);
        chk("rs_retrig", g_retrig, 1);
        chk("rs_ovf",    g_ovf, 0);
        send(0, 1, 60, 0, 2, 0);
        chk("rs_off60_note", int'(out_note), 62);
        chk("rs_off60_vel",  int'(out_vel), 20);
        send(0, 1, 62, 0, 2, 0);
        chk("rs_clear_gate", int'(out_gate), 0);

        // Strobe while busy, and simultaneous on/off.
        send(1, 0, 70, 1, 0, 1);
        chk("busy_drop",  g_drop, 1);
        chk("busy_note",  int'(out_note), 70);
        send(0, 1, 100, 0, 0, 0);
        chk("busy_unchanged_lat",  g_lat, 1);
        chk("busy_unchanged_note", int'(out_note), 70);
        send(1, 1, 72, 5, 0, 0);
        chk("both_drop",   g_drop, 1);
        chk("both_note",   int'(out_note), 72);
        chk("both_retrig", g_retrig, 1);
        send(0, 1, 70, 0, 0, 0);
        send(0, 1, 72, 0, 0, 0);
        chk("both_clear_gate", int'(out_gate), 0);

        // Fill to capacity in lowest mode, then steal.
        for (int i = 0; i < 32; i++) begin
            send(1, 0, 40 + i, i + 1, 1, 0);
        end
        chk("fill_note", int'(out_note), 40);
        chk("fill_vel",  int'(out_vel), 1);
        send(1, 0, 30, 5, 1, 0);
        chk("steal_lat",    g_lat, 97);
        chk("steal_ovf",    g_ovf, 1);
        chk("steal_note",   int'(out_note), 30);
        chk("steal_vel",    int'(out_vel), 5);
        chk("steal_retrig", g_retrig, 1);
        send(0, 1, 30, 0, 1, 0);
        chk("steal_off_lat",  g_lat, 64);
        chk("steal_off_note", int'(out_note), 41);
        chk("steal_off_vel",  int'(out_vel), 2);

        // Reset in the middle of SHIFT (31 scan cycles, then shifting).
        @(negedge clk);
        note_off = 1'b1;
        note     = 7'd41;
        mode     = 2'd1;
        @(negedge clk);
        note_off = 1'b0;
        repeat (35) @(negedge clk);
        chk("mid_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_gate",  int'(out_gate), 0);
        chk("mid_rst_note",  int'(out_note), 0);
        chk("mid_rst_vel",   int'(out_vel), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_pulse", int'({out_retrig, dropped, overflow}), 0);
        @(negedge clk);
        rst = 1'b1;
        send(1, 0, 50, 9, 0, 0);
        chk("post_rst_lat",    g_lat, 4);
        chk("post_rst_note",   int'(out_note), 50);
        chk("post_rst_retrig", g_retrig, 1);
        send(0, 1, 50, 0, 0, 0);
        chk("post_rst_off_lat",  g_lat, 3);
        chk("post_rst_off_gate", int'(out_gate), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
